tpu_host_if: RTL and testbench
==============================

TPU_HOST_IF -- requirements
Module: tpu_host_if

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of every matrix row/column word (4 packed 8-bit elements).
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum cycles to wait for done_bit after go_bit rises.
REQ-003 SHALL have port clk, input, 1: single clock. The block SHALL use one clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port wr_en, input, 1: host write strobe, one cycle per write.
REQ-006 SHALL have port rd_en, input, 1: host read strobe, one cycle per read.
REQ-007 SHALL have port addr, input, 4: host register index.
REQ-008 SHALL have port wdata, input, DATA_WIDTH: host write data.
REQ-009 SHALL have port rdata, output, DATA_WIDTH: registered host read data.
REQ-010 SHALL have port rdata_valid, output, 1: rdata is valid this cycle.
REQ-011 SHALL have port irq, output, 1: level interrupt, set on completion or timeout.
REQ-012 SHALL have ports rowA0..rowA3 and colB0..colB3, output, DATA_WIDTH each: matrix operands to the array.
REQ-013 SHALL have port go_bit, output, 1: start request to the array.
REQ-014 SHALL have port done_bit, input, 1: completion from the array.
REQ-015 SHALL have ports rowC0..rowC3, input, DATA_WIDTH each: result rows from the array.

Function
REQ-016 SHALL use this address map: 0-3 A rows (RW); 4-7 B columns (RW); 8-11 captured C rows (RO); 12 CTRL (W: bit0 start, bit1 irq_clear); 13 STATUS (R: bit0 busy, bit1 done, bit2 timeout, bits[15:8] last cycle count).
REQ-017 SHALL drive rowA*/colB* directly from the A/B registers.
REQ-018 SHALL implement the FSM IDLE -> RUN -> CAPTURE -> IDLE.
- IDLE: a start write moves to RUN on the next edge.
- RUN: go_bit=1. done_bit=1 moves to CAPTURE. Cycle counter reaching TIMEOUT moves to IDLE with timeout=1.
- CAPTURE: one cycle, go_bit=0, then IDLE.
REQ-019 SHALL assert go_bit only in RUN, as a level held until done_bit or timeout.
REQ-020 SHALL latch rowC0..rowC3 into the C registers on the edge where done_bit=1 in RUN, and set done=1 and irq=1.
REQ-021 SHALL ignore done_bit outside RUN.
REQ-022 SHALL have an 8-bit cycle counter:
- cleared on entry to RUN;
- incremented each RUN cycle, saturating at 255;
- value copied to STATUS[15:8] on leaving RUN.
REQ-023 SHALL on timeout set timeout=1 and irq=1, leave the C registers unchanged, and drop go_bit the following cycle.
REQ-024 SHALL on a start write clear done and timeout.
REQ-025 SHALL report busy=1 in RUN and CAPTURE.
REQ-026 SHALL ignore, while busy, writes to A/B and start writes; irq_clear SHALL still act.
REQ-027 SHALL on an irq_clear write drop irq the next cycle; if irq_clear and a completion occur in the same cycle, the completion SHALL win (irq=1).
REQ-028 SHALL return read data one cycle after rd_en with rdata_valid=1 for exactly one cycle; rdata_valid=0 SHALL hold rdata at its last value.
REQ-029 SHALL return 0 on reads of unmapped addresses (14, 15) and of CTRL; writes to RO or unmapped addresses SHALL have no effect.
REQ-030 SHALL serve wr_en and rd_en in the same cycle, to the same address, with the read returning the pre-write value.

Reset
REQ-031 SHALL, while rst_n=0, immediately force: FSM=IDLE, go_bit=0, irq=0, rdata_valid=0, rdata=0, all A/B/C registers=0, done=timeout=0, counter=0.
REQ-032 SHALL, on reset during RUN, abort the operation with no C capture and no irq after release.

Verification
REQ-033 SHALL cover: write A rows 0x01020304.., B cols, start; done_bit after 10 cycles with rowC0=0x11223344 -> read addr 8 returns 0x11223344, STATUS=0x00000A02 (done, count 10, busy=0), irq=1.
REQ-034 SHALL cover: start with done_bit never asserted -> go_bit falls at TIMEOUT=64; STATUS bit2=1, bits[15:8]=64; C registers unchanged; irq=1.
REQ-035 SHALL cover: write addr 0 = 0xDEADBEEF during RUN -> rowA0 unchanged; second start ignored; busy=1.
REQ-036 SHALL cover: irq_clear written in the same cycle done_bit=1 -> irq remains 1; a later irq_clear -> irq=0.
REQ-037 SHALL cover: rst_n pulsed low mid-RUN -> go_bit=0 asynchronously, all outputs 0; no irq after release.
REQ-038 SHALL cover: rd_en and wr_en together at addr 5 with wdata=0x55 over old value 0x12 -> rdata=0x12 with rdata_valid=1; the next read returns 0x55.

Source files
------------

// File: rtl/tpu_host_if.sv
// ============================================================================
// Module   : tpu_host_if
// Purpose  : Host register file and start/done sequencer for a 4x4 matrix array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tpu_host_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [3:0]            addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  irq,
  output logic [DATA_WIDTH-1:0] rowA0,
  output logic [DATA_WIDTH-1:0] rowA1,
  output logic [DATA_WIDTH-1:0] rowA2,
  output logic [DATA_WIDTH-1:0] rowA3,
  output logic [DATA_WIDTH-1:0] colB0,
  output logic [DATA_WIDTH-1:0] colB1,
  output logic [DATA_WIDTH-1:0] colB2,
  output logic [DATA_WIDTH-1:0] colB3,
  output logic                  go_bit,
  input  logic                  done_bit,
  input  logic [DATA_WIDTH-1:0] rowC0,
  input  logic [DATA_WIDTH-1:0] rowC1,
  input  logic [DATA_WIDTH-1:0] rowC2,
  input  logic [DATA_WIDTH-1:0] rowC3
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_RUN     = 2'd1;
  localparam logic [1:0] c_CAPTURE = 2'd2;
  // The counter saturates at 255, so larger limits are clipped to stay reachable.
  localparam logic [8:0] c_TMO = (TIMEOUT > 255) ? 9'd255 : 9'(TIMEOUT);

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_a [4];
  logic [DATA_WIDTH-1:0] r_b [4];
  logic [DATA_WIDTH-1:0] r_c [4];
  logic                  r_done;
  logic                  r_tmo;
  logic [7:0]            r_cnt;
  logic [7:0]            r_last;

  logic                  w_busy;
  logic                  w_wr_ctrl;
  logic                  w_start;
  logic                  w_irq_clr;
  logic [8:0]            w_cnt_inc;
  logic [7:0]            w_cnt_sat;
  logic                  w_finish;
  logic                  w_tmo_hit;
  logic [DATA_WIDTH-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_rd_mux;

  assign w_busy    = (r_state != c_IDLE);
  assign w_wr_ctrl = wr_en && (addr == 4'd12);
  assign w_start   = w_wr_ctrl && wdata[0] && !w_busy;
  assign w_irq_clr = w_wr_ctrl && wdata[1];
  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
  assign w_cnt_sat = (r_cnt == 8'hFF) ? 8'hFF : w_cnt_inc[7:0];
  assign w_finish  = (r_state == c_RUN) && done_bit;
  // Completion takes precedence over a timeout landing on the same edge.
  assign w_tmo_hit = (r_state == c_RUN) && !done_bit && (w_cnt_inc >= c_TMO);
  assign w_status  = {{(DATA_WIDTH-16){1'b0}}, r_last, 5'd0, r_tmo, r_done, w_busy};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_done  <= 1'b0;
      r_tmo   <= 1'b0;
      r_cnt   <= 8'd0;
      r_last  <= 8'd0;
      for (int i = 0; i < 4; i++) r_c[i] <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_start) begin
            r_state <= c_RUN;
            r_cnt   <= 8'd0;
            r_done  <= 1'b0;
            r_tmo   <= 1'b0;
          end
        end
        c_RUN: begin
          r_cnt <= w_cnt_sat;
          if (done_bit) begin
            r_state <= c_CAPTURE;
            r_done  <= 1'b1;
            r_last  <= w_cnt_sat;
            r_c[0]  <= rowC0;
            r_c[1]  <= rowC1;
            r_c[2]  <= rowC2;
            r_c[3]  <= rowC3;
          end else if (w_tmo_hit) begin
            r_state <= c_IDLE;
            r_tmo   <= 1'b1;
            r_last  <= w_cnt_sat;
          end
        end
        c_CAPTURE: r_state <= c_IDLE;
        default:   r_state <= c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (w_finish || w_tmo_hit) begin
      irq <= 1'b1;
    end else if (w_irq_clr) begin
      irq <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else if (wr_en && !w_busy && !addr[3]) begin
      if (addr[2]) r_b[addr[1:0]] <= wdata;
      else         r_a[addr[1:0]] <= wdata;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (addr[3:2])
      2'd0:    w_rd_mux = r_a[addr[1:0]];
      2'd1:    w_rd_mux = r_b[addr[1:0]];
      2'd2:    w_rd_mux = r_c[addr[1:0]];
      default: w_rd_mux = (addr == 4'd13) ? w_status : '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= rd_en;
      if (rd_en) rdata <= w_rd_mux;
    end
  end

  assign go_bit = (r_state == c_RUN);
  assign rowA0  = r_a[0];
  assign rowA1  = r_a[1];
  assign rowA2  = r_a[2];
  assign rowA3  = r_a[3];
  assign colB0  = r_b[0];
  assign colB1  = r_b[1];
  assign colB2  = r_b[2];
  assign colB3  = r_b[3];

endmodule

`default_nettype wire

// File: tb/tb_tpu_host_if.sv
// ============================================================================
// Module   : tb_tpu_host_if
// Purpose  : Randomized self-checking bench for tpu_host_if against a register-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tpu_host_if;

  localparam int DW  = 32;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [3:0]    addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          irq;
  logic [DW-1:0] rowA0, rowA1, rowA2, rowA3;
  logic [DW-1:0] colB0, colB1, colB2, colB3;
  logic          go_bit;
  logic          done_bit = 1'b0;
  logic [DW-1:0] c_in [4];

  tpu_host_if #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid), .irq(irq),
    .rowA0(rowA0), .rowA1(rowA1), .rowA2(rowA2), .rowA3(rowA3),
    .colB0(colB0), .colB1(colB1), .colB2(colB2), .colB3(colB3),
    .go_bit(go_bit), .done_bit(done_bit),
    .rowC0(c_in[0]), .rowC1(c_in[1]), .rowC2(c_in[2]), .rowC3(c_in[3])
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register contents and flags at transaction level
  logic [DW-1:0] m_a [4];
  logic [DW-1:0] m_b [4];
  logic [DW-1:0] m_c [4];
  bit            m_done, m_tmo, m_irq, m_busy;
  int            m_cnt;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input int a);
    if (a < 4)       return m_a[a];
    else if (a < 8)  return m_b[a-4];
    else if (a < 12) return m_c[a-8];
    else if (a == 13) return {16'd0, 8'(m_cnt), 5'd0, m_tmo, m_done, m_busy};
    else             return '0;
  endfunction

  function automatic logic [DW-1:0] port_val(input int i);
    case (i)
      0: return rowA0; 1: return rowA1; 2: return rowA2; 3: return rowA3;
      4: return colB0; 5: return colB1; 6: return colB2; default: return colB3;
    endcase
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin m_a[i] = '0; m_b[i] = '0; m_c[i] = '0; end
    m_done = 0; m_tmo = 0; m_irq = 0; m_busy = 0; m_cnt = 0;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; done_bit = 1'b0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    addr = 4'(a); wdata = d; wr_en = 1'b1;
    cyc();
    if (!m_busy && a < 4) m_a[a] = d;
    else if (!m_busy && a < 8) m_b[a-4] = d;
  endtask

  task automatic rd(input int a, output logic [DW-1:0] d);
    addr = 4'(a); rd_en = 1'b1;
    cyc();
    check("rd_valid", rdata_valid, 1);
    d = rdata;
  endtask

  task automatic rd_chk(input int a, input string tag);
    logic [DW-1:0] d;
    rd(a, d);
    check(tag, d, m_read(a));
  endtask

  // One start/complete operation; lat > TMO means done_bit never comes.
  task automatic run_op(input int lat, input bit meddle, input bit clr_with_done,
                        input logic [DW-1:0] c0);
    logic [DW-1:0] newc [4];
    for (int i = 0; i < 4; i++) newc[i] = $urandom;
    newc[0] = c0;
    for (int i = 0; i < 4; i++) c_in[i] = $urandom;
    wr(12, 1);
    m_busy = 1; m_done = 0; m_tmo = 0;
    check("go_rise", go_bit, 1);
    for (int e = 1; e <= TMO; e++) begin
      if (e == lat) begin
        done_bit = 1'b1;
        for (int i = 0; i < 4; i++) c_in[i] = newc[i];
        if (clr_with_done) begin addr = 4'd12; wdata = 2; wr_en = 1'b1; end
      end
      if (meddle && e == 2) begin addr = 4'd0; wdata = 32'hDEADBEEF; wr_en = 1'b1; end
      if (meddle && e == 3) begin addr = 4'd12; wdata = 1; wr_en = 1'b1; end
      if (meddle && e == 4) begin addr = 4'd13; rd_en = 1'b1; end
      cyc();
      if (meddle && e == 2) check("rowA0_locked", rowA0, m_a[0]);
      if (meddle && e == 4) check("busy_bit", {31'd0, rdata[0]}, 1);
      if (e == lat) break;
      if (e == TMO - 1) check("go_held", go_bit, 1);
    end
    m_irq = 1;
    if (lat <= TMO) begin
      for (int i = 0; i < 4; i++) m_c[i] = newc[i];
      m_done = 1; m_cnt = lat;
      check("go_fall_done", go_bit, 0);
      for (int i = 0; i < 4; i++) c_in[i] = $urandom;
      cyc();
    end else begin
      m_tmo = 1; m_cnt = TMO;
      check("go_fall_tmo", go_bit, 0);
    end
    m_busy = 0;
    check("irq_set", irq, m_irq);
    rd_chk(13, "status");
    for (int i = 8; i < 12; i++) rd_chk(i, "c_reg");
  endtask

  initial begin
    logic [DW-1:0] d;
    m_reset();
    for (int i = 0; i < 4; i++) c_in[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_go", go_bit, 0);
    check("rst_irq", irq, 0);
    check("rst_rdata", rdata, 0);
    check("rst_valid", rdata_valid, 0);
    rst_n = 1'b1;
    cyc();
    rd_chk(13, "rst_status");

    // Basic completion with known C row
    for (int i = 0; i < 4; i++) wr(i, 32'h01020304 + 32'(i) * 32'h04040404);
    for (int i = 4; i < 8; i++) wr(i, $urandom);
    for (int i = 0; i < 8; i++) check("port_ab", port_val(i), m_read(i));
    run_op(10, 0, 0, 32'h11223344);
    rd(8, d);
    check("c0_const", d, 32'h11223344);
    rd(13, d);
    check("status_const", d, 32'h00000A02);

    // Timeout: C registers untouched
    run_op(TMO + 20, 0, 0, $urandom);

    // Writes and start ignored while busy
    run_op(12, 1, 0, $urandom);
    check("rowA0_after", rowA0, m_a[0]);

    // irq_clear colliding with completion, then a plain clear
    run_op(7, 0, 1, $urandom);
    wr(12, 2); m_irq = 0;
    check("irq_clr", irq, 0);

    // Simultaneous read and write at one address
    wr(5, 32'h12);
    addr = 4'd5; wdata = 32'h55; wr_en = 1'b1; rd_en = 1'b1; m_b[1] = 32'h55;
    cyc();
    check("rw_valid", rdata_valid, 1);
    check("rw_old", rdata, 32'h12);
    cyc();
    check("valid_pulse", rdata_valid, 0);
    check("rdata_hold", rdata, 32'h12);
    rd_chk(5, "rw_new");

    // Randomized register traffic
    for (int it = 0; it < 60; it++) begin
      int r, a;
      r = $urandom_range(0, 8);
      if (r <= 3) begin
        a = $urandom_range(0, 7);
        wr(a, $urandom);
        check("rand_port", port_val(a), m_read(a));
      end else if (r <= 6) begin
        rd_chk($urandom_range(0, 15), "rand_rd");
      end else if (r == 7) begin
        a = $urandom_range(0, 7);
        a = (a < 4) ? a + 8 : a + 9;
        wr(a, $urandom);
        rd_chk(a, "ro_rd");
      end else begin
        cyc();
        check("idle_valid", rdata_valid, 0);
      end
    end
    for (int k = 0; k < 4; k++) run_op($urandom_range(1, TMO + 16), 0, 0, $urandom);
    for (int i = 0; i < 8; i++) check("port_final", port_val(i), m_read(i));

    // Reset pulsed in the middle of a run
    wr(12, 1);
    repeat (5) cyc();
    check("pre_rst_go", go_bit, 1);
    rst_n = 1'b0;
    #1;
    m_reset();
    check("arst_go", go_bit, 0);
    check("arst_irq", irq, 0);
    check("arst_rdata", rdata, 0);
    check("arst_rowA0", rowA0, 0);
    check("arst_colB3", colB3, 0);
    cyc();
    rst_n = 1'b1;
    repeat (TMO + 5) cyc();
    check("post_rst_irq", irq, 0);
    check("post_rst_go", go_bit, 0);
    rd_chk(13, "post_rst_status");
    rd_chk(8, "post_rst_c0");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
